// File: rtl/axi_cmd_reg_map.sv
// Register-map writer: decodes {opcode, id, addr/data pairs} command frames into a flat
// register bank and answers every frame with a 3-word acknowledge on the response stream.
module axi_cmd_reg_map #(
    parameter int          REG_WIDTH = 4,
    parameter int          NUM_REG   = 6,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                           axi_tclk,
    input  logic                           axi_tresetn,
    input  logic [31:0]                    s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [31:0]                    m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [NUM_REG*8*REG_WIDTH-1:0] reg_map_data,
    output logic                           reg_wr_strobe,
    output logic [7:0]                     reg_wr_addr,
    output logic [31:0]                    cmd_id_out
);

    localparam int          RW       = 8 * REG_WIDTH;
    localparam logic [RW-1:0] REG_RST = RESET_VAL[RW-1:0];
    localparam logic [31:0] OP_WRITE = 32'h5757_5757;
    localparam logic [31:0] ACK_WORD = 32'h4143_4B21;

    typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_DATA, S_DROP, S_RESP} state_t;

    state_t        state_q;
    logic [1:0]    resp_idx_q;
    logic [31:0]   id_q;
    logic [7:0]    addr_q;
    logic          bad_op_q;
    logic          trunc_q;
    logic [15:0]   wr_cnt_q;
    logic [7:0]    bad_addr_cnt_q;
    logic [RW-1:0] regs_q [NUM_REG];
    logic          s_tready_q;
    logic          m_tvalid_q;
    logic          m_tlast_q;
    logic [31:0]   m_tdata_q;
    logic          strobe_q;
    logic [7:0]    wr_addr_q;
    logic [31:0]   cmd_id_q;

    logic [15:0]   wr_cnt_d;
    logic [7:0]    bad_addr_cnt_d;
    logic [31:0]   status_d;
    logic          beat;
    logic          m_hs;
    logic          addr_ok;

    always_comb begin
        beat           = s_axis_tvalid && s_tready_q;
        m_hs           = m_tvalid_q && m_axis_tready;
        addr_ok        = ({24'd0, addr_q} < 32'(NUM_REG));
        wr_cnt_d       = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
        bad_addr_cnt_d = (bad_addr_cnt_q == 8'hFF) ? bad_addr_cnt_q : bad_addr_cnt_q + 8'd1;
        status_d       = {bad_op_q, trunc_q, 6'b0, bad_addr_cnt_q, wr_cnt_q};
    end

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            state_q        <= S_IDLE;
            resp_idx_q     <= 2'd0;
            id_q           <= 32'd0;
            addr_q         <= 8'd0;
            bad_op_q       <= 1'b0;
            trunc_q        <= 1'b0;
            wr_cnt_q       <= 16'd0;
            bad_addr_cnt_q <= 8'd0;
            s_tready_q     <= 1'b0;
            m_tvalid_q     <= 1'b0;
            m_tlast_q      <= 1'b0;
            m_tdata_q      <= 32'd0;
            strobe_q       <= 1'b0;
            wr_addr_q      <= 8'd0;
            cmd_id_q       <= 32'd0;
            for (int k = 0; k < NUM_REG; k++) regs_q[k] <= REG_RST;
        end else begin
            strobe_q <= 1'b0;
            if (state_q != S_RESP) s_tready_q <= 1'b1;
            case (state_q)
                S_IDLE: if (beat) begin
                    wr_cnt_q       <= 16'd0;
                    bad_addr_cnt_q <= 8'd0;
                    id_q           <= 32'd0;
                    bad_op_q       <= (s_axis_tdata != OP_WRITE);
                    trunc_q        <= s_axis_tlast;
                    state_q        <= (s_axis_tdata == OP_WRITE) ? S_ID : S_DROP;
                end
                S_ID: if (beat) begin
                    id_q    <= s_axis_tdata;
                    state_q <= S_ADDR;
                end
                S_ADDR: if (beat) begin
                    addr_q  <= s_axis_tdata[7:0];
                    trunc_q <= s_axis_tlast;
                    state_q <= S_DATA;
                end
                S_DATA: if (beat) begin
                    if (addr_ok) begin
                        for (int k = 0; k < NUM_REG; k++)
                            if (addr_q == 8'(k)) regs_q[k] <= s_axis_tdata[RW-1:0];
                        strobe_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_cnt_q  <= wr_cnt_d;
                    end else begin
                        bad_addr_cnt_q <= bad_addr_cnt_d;
                    end
                    state_q <= S_ADDR;
                end
                S_DROP: begin
                end
                S_RESP: if (m_hs) begin
                    case (resp_idx_q)
                        2'd0: begin
                            m_tdata_q  <= id_q;
                            resp_idx_q <= 2'd1;
                        end
                        2'd1: begin
                            m_tdata_q  <= status_d;
                            m_tlast_q  <= 1'b1;
                            resp_idx_q <= 2'd2;
                        end
                        default: begin
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            m_tdata_q  <= 32'd0;
                            cmd_id_q   <= id_q;
                            s_tready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
            // Any tlast beat, whatever the decode state, closes the frame and starts the ack.
            if (beat && s_axis_tlast) begin
                state_q    <= S_RESP;
                s_tready_q <= 1'b0;
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= 1'b0;
                m_tdata_q  <= ACK_WORD;
                resp_idx_q <= 2'd0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REG; g++) begin : g_flat
        assign reg_map_data[g*RW +: RW] = regs_q[g];
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign reg_wr_strobe = strobe_q;
    assign reg_wr_addr   = wr_addr_q;
    assign cmd_id_out    = cmd_id_q;

endmodule

// File: tb/tb_axi_cmd_reg_map.sv
// Bench for axi_cmd_reg_map: table vectors, hand sequences and random frames vs a frame-level model.
module tb_axi_cmd_reg_map;

    localparam int          NREG = 6;
    localparam logic [31:0] RVAL = 32'hA5A5_0F0F;
    localparam logic [31:0] OPW  = 32'h5757_5757;
    localparam logic [31:0] ACK  = 32'h4143_4B21;

    logic              axi_tclk;
    logic              axi_tresetn;
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [NREG*32-1:0] reg_map_data;
    logic              reg_wr_strobe;
    logic [7:0]        reg_wr_addr;
    logic [31:0]       cmd_id_out;

    axi_cmd_reg_map #(.REG_WIDTH(4), .NUM_REG(NREG), .RESET_VAL(RVAL)) dut (
        .axi_tclk      (axi_tclk),
        .axi_tresetn   (axi_tresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .reg_map_data  (reg_map_data),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_wr_addr   (reg_wr_addr),
        .cmd_id_out    (cmd_id_out)
    );

    initial axi_tclk = 1'b0;
    always #5 axi_tclk = ~axi_tclk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] mon_w[$];
    logic [39:0] mon_s[$];
    logic [31:0] fq[$];
    logic [31:0] mregs[NREG];
    logic [39:0] exp_s[$];
    logic [31:0] m_id;
    logic [31:0] m_st;
    bit          rdy_rand = 1'b0;
    bit          rdy_force = 1'b1;

    typedef struct {
        logic [31:0] w[8];
        int          n;
        logic [31:0] id;
        logic [31:0] st;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic abort_run(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the DUT", nm);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "stopping after timeout");
    endtask

    // Observe handshakes and strobes between edges.
    always @(negedge axi_tclk) begin
        if (m_axis_tvalid && m_axis_tready) mon_w.push_back({m_axis_tlast, m_axis_tdata});
        if (reg_wr_strobe)
            mon_s.push_back({reg_wr_addr, (reg_wr_addr < NREG) ? reg_map_data[reg_wr_addr*32 +: 32] : 32'hXXXXXXXX});
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axi_tclk);
            #1;
            m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Frame-level reference: interprets the whole word list at once.
    task automatic model_frame();
        int   n;
        int   wr;
        int   ba;
        bit   bad;
        bit   tr;
        logic [7:0] a;
        n = fq.size();
        wr = 0;
        ba = 0;
        tr = 0;
        exp_s.delete();
        m_id = 32'd0;
        bad = (fq[0] != OPW);
        if (n == 1) tr = 1;
        else if (!bad) begin
            m_id = fq[1];
            if ((n - 2) % 2 == 1) tr = 1;
            for (int i = 2; i + 1 < n; i += 2) begin
                a = fq[i][7:0];
                if (a < NREG) begin
                    for (int k = 0; k < NREG; k++) if (a == 8'(k)) mregs[k] = fq[i+1];
                    exp_s.push_back({a, fq[i+1]});
                    if (wr < 65535) wr++;
                end else if (ba < 255) ba++;
            end
        end
        m_st = {bad, tr, 6'b0, 8'(ba), 16'(wr)};
    endtask

    task automatic wait_ready();
        int cyc = 0;
        @(negedge axi_tclk);
        while (!s_axis_tready && cyc < 300) begin
            cyc++;
            @(negedge axi_tclk);
        end
        if (!s_axis_tready) abort_run("s_tready_wait");
    endtask

    task automatic drive_words(input int n, input bit last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge axi_tclk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fq[i];
            s_axis_tlast  = last && (i == n - 1);
            wait_ready();
            @(posedge axi_tclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_resp(input logic [31:0] xid, input logic [31:0] xst, input string tag);
        int cyc = 0;
        while (mon_w.size() < 3 && cyc < 400) begin
            @(negedge axi_tclk);
            cyc++;
        end
        if (mon_w.size() < 3) abort_run({tag, "_resp"});
        chk({tag, "_w0"}, mon_w[0], {1'b0, ACK});
        chk({tag, "_w1"}, mon_w[1], {1'b0, xid});
        chk({tag, "_w2"}, mon_w[2], {1'b1, xst});
        @(posedge axi_tclk);
        #1;
        chk({tag, "_nwords"}, mon_w.size(), 3);
        chk({tag, "_cmd_id"}, cmd_id_out, xid);
        chk({tag, "_s_tready"}, s_axis_tready, 1'b1);
        chk({tag, "_nstrobes"}, mon_s.size(), exp_s.size());
        for (int i = 0; i < mon_s.size() && i < exp_s.size(); i++)
            chk($sformatf("%s_strobe%0d", tag, i), mon_s[i], exp_s[i]);
        for (int k = 0; k < NREG; k++)
            chk($sformatf("%s_reg%0d", tag, k), reg_map_data[k*32 +: 32], mregs[k]);
    endtask

    task automatic run_frame(input bit gaps, input bit use_x, input logic [31:0] xid,
                             input logic [31:0] xst, input string tag);
        mon_w.delete();
        mon_s.delete();
        model_frame();
        drive_words(fq.size(), 1'b1, gaps);
        check_resp(use_x ? xid : m_id, use_x ? xst : m_st, tag);
    endtask

    initial begin
        logic [31:0] tmp;
        int          n;
        tbl[0] = '{'{OPW, 32'd5, 32'd2, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0}, 4, 32'd5, 32'h0000_0001};
        tbl[1] = '{'{OPW, 32'd7, 32'd0, 32'h1111_1111, 32'd9, 32'h2222_2222, 32'd5, 32'h3333_3333}, 8, 32'd7, 32'h0001_0002};
        tbl[2] = '{'{OPW, 32'd8, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 3, 32'd8, 32'h4000_0000};
        tbl[3] = '{'{32'h1234_5678, 32'hAAAA_0001, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0}, 5, 32'd0, 32'h8000_0000};
        tbl[4] = '{'{OPW, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 2, 32'd9, 32'h0000_0000};
        tbl[5] = '{'{OPW, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1, 32'd0, 32'h4000_0000};
        tbl[6] = '{'{32'h1234_5678, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1, 32'd0, 32'hC000_0000};
        tbl[7] = '{'{OPW, 32'hA, 32'd3, 32'd1, 32'd3, 32'd2, 32'd0, 32'd0}, 6, 32'hA, 32'h0000_0002};
        tbl[8] = '{'{OPW, 32'hB, 32'hFFFF_FF04, 32'hCAFE_F00D, 32'd6, 32'd1, 32'd5, 32'd55}, 8, 32'hB, 32'h0001_0002};

        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tlast  = 1'b0;
        axi_tresetn   = 1'b0;
        for (int k = 0; k < NREG; k++) mregs[k] = RVAL;
        repeat (3) @(posedge axi_tclk);
        #1;
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_strobe", reg_wr_strobe, 1'b0);
        chk("rst_wr_addr", reg_wr_addr, 8'd0);
        chk("rst_cmd_id", cmd_id_out, 32'd0);
        for (int k = 0; k < NREG; k++) chk($sformatf("rst_reg%0d", k), reg_map_data[k*32 +: 32], RVAL);
        axi_tresetn = 1'b1;
        @(negedge axi_tclk);
        chk("rel_s_tready_before_clk", s_axis_tready, 1'b0);
        @(negedge axi_tclk);
        chk("rel_s_tready_after_clk", s_axis_tready, 1'b1);
        @(posedge axi_tclk);
        #1;

        for (int t = 0; t < 9; t++) begin
            fq.delete();
            for (int j = 0; j < tbl[t].n; j++) fq.push_back(tbl[t].w[j]);
            run_frame(1'b0, 1'b1, tbl[t].id, tbl[t].st, $sformatf("tbl%0d", t));
            if (t == 0) chk("tbl0_reg2_deadbeef", reg_map_data[95:64], 32'hDEADBEEF);
        end

        // Bad-address counter saturates at 0xFF.
        fq.delete();
        fq.push_back(OPW);
        fq.push_back(32'hC);
        for (int i = 0; i < 300; i++) begin
            fq.push_back(32'h80);
            fq.push_back(32'(i));
        end
        run_frame(1'b0, 1'b1, 32'hC, 32'h00FF_0000, "badsat");

        // Response back-pressure: word 0 must hold while the input stays stalled.
        fq.delete();
        fq.push_back(OPW);
        fq.push_back(32'h77);
        fq.push_back(32'd1);
        fq.push_back(32'h1234_5678);
        mon_w.delete();
        mon_s.delete();
        model_frame();
        rdy_force = 1'b0;
        repeat (2) @(posedge axi_tclk);
        #1;
        drive_words(4, 1'b1, 1'b0);
        repeat (10) begin
            @(negedge axi_tclk);
            chk("bp_m_tvalid", m_axis_tvalid, 1'b1);
            chk("bp_w0_hold", m_axis_tdata, ACK);
            chk("bp_s_tready", s_axis_tready, 1'b0);
        end
        rdy_force = 1'b1;
        check_resp(32'h77, 32'h0000_0001, "bp");

        // Reset in the middle of a DATA beat.
        fq.delete();
        fq.push_back(OPW);
        fq.push_back(32'h99);
        fq.push_back(32'd3);
        drive_words(3, 1'b0, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hBAD0_BAD0;
        #2;
        axi_tresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_s_tready", s_axis_tready, 1'b0);
        chk("mid_rst_cmd_id", cmd_id_out, 32'd0);
        for (int k = 0; k < NREG; k++) chk($sformatf("mid_rst_reg%0d", k), reg_map_data[k*32 +: 32], RVAL);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < NREG; k++) mregs[k] = RVAL;
        @(posedge axi_tclk);
        #1;
        axi_tresetn = 1'b1;
        @(posedge axi_tclk);
        #1;
        fq.delete();
        fq.push_back(OPW);
        fq.push_back(32'h1234);
        fq.push_back(32'd2);
        fq.push_back(32'h0BAD_F00D);
        run_frame(1'b0, 1'b1, 32'h1234, 32'h0000_0001, "post_rst");

        // Random frames, random gaps and random response back-pressure.
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fq.delete();
            fq.push_back(($urandom_range(0, 9) == 0) ? $urandom : OPW);
            n = $urandom_range(1, 12);
            for (int i = 1; i < n; i++) begin
                tmp = $urandom;
                if (i >= 2 && (i % 2) == 0) tmp[7:0] = 8'($urandom_range(0, 8));
                fq.push_back(tmp);
            end
            run_frame(1'b1, 1'b0, 32'd0, 32'd0, $sformatf("rnd%0d", f));
        end
        rdy_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_cmd_reg_map.md
# axi_cmd_reg_map

Register-map writer sitting directly downstream of the RX command generator. It consumes the 32-bit AXI-Stream command frames that stage forwards (opcode word, command ID, then address/data pairs) and writes the payload into a flat bank of NUM_REG control registers. For every frame it returns a 3-word acknowledge frame on a response stream.

## Interface
- REG_WIDTH, 4: register width in bytes, legal 1..4; the register stores data word bits [8*REG_WIDTH-1:0].
- NUM_REG, 6: number of registers, legal 1..255.
- RESET_VAL, 0: 32-bit reset value of every register, truncated to the register width.
- axi_tclk  in  1  sole clock.
- axi_tresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  command stream data.
- s_axis_tvalid  in  1  command stream valid.
- s_axis_tlast  in  1  last word of the command frame.
- s_axis_tready  out  1  command stream ready.
- m_axis_tdata  out  32  acknowledge stream data.
- m_axis_tvalid  out  1  acknowledge stream valid.
- m_axis_tlast  out  1  asserted on acknowledge word 2.
- m_axis_tready  in  1  acknowledge stream ready.
- reg_map_data  out  NUM_REG*8*REG_WIDTH  flat register bank; register k occupies bits [(k+1)*8*REG_WIDTH-1 : k*8*REG_WIDTH].
- reg_wr_strobe  out  1  one-cycle pulse per register write.
- reg_wr_addr  out  8  index of the register written; valid with reg_wr_strobe.
- cmd_id_out  out  32  ID of the last fully acknowledged frame.

## Operation
- Beat: a beat is accepted on a clock edge where s_axis_tvalid and s_axis_tready are both high.
- Frame format:
  - word0 is the opcode. WRITE = 0x57575757. Any other value is a bad opcode.
  - word1 is the command ID.
  - Remaining words are {addr, data} pairs.
- States: IDLE, ID, ADDR, DATA, DROP, RESP.
- IDLE:
  - Accepting a beat clears the status counters.
  - The opcode is latched.
  - Next state is ID. If the opcode is bad, next state is DROP with bad_opcode set.
  - If tlast is set on this beat, next state is RESP with truncated set.
- ID:
  - The beat latches the ID.
  - tlast set: go to RESP. No pairs is legal and is not truncated.
  - Otherwise: go to ADDR.
- ADDR:
  - The beat latches tdata[7:0] as the address; upper bits are ignored.
  - tlast set: set truncated and go to RESP.
  - Otherwise: go to DATA.
- DATA:
  - If addr < NUM_REG: write the register, pulse reg_wr_strobe, increment wr_count (saturates at 0xFFFF).
  - If addr >= NUM_REG: no write, increment bad_addr_count (saturates at 0xFF).
  - tlast set: go to RESP. Otherwise: go to ADDR.
- DROP: consume beats until a tlast beat, then go to RESP. A bad-opcode frame still gets its ID field reported as 0.
- RESP: emit three words.
  - Word 0: 0x41434B21.
  - Word 1: the latched ID.
  - Word 2: status = {bad_opcode, truncated, 6'b0, bad_addr_count[7:0], wr_count[15:0]}.
  - After word 2 is accepted: cmd_id_out is updated with the latched ID, and the state returns to IDLE.
- s_axis_tready is 1 in IDLE, ID, ADDR, DATA and DROP, and 0 in RESP. Frames are never dropped by the block; it back-pressures instead.

## Timing
- Reset values:
  - s_axis_tready = 0 while reset is asserted; it rises on the first clock after release.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - reg_wr_strobe = 0, reg_wr_addr = 0, cmd_id_out = 0.
  - Every register = RESET_VAL.
  - State = IDLE.
- Reset asserted mid-frame: all outputs and state return to reset values immediately. After release the block expects a new frame starting at its opcode word; it does not re-sync to the remainder of the interrupted frame.
- Register write:
  - The new value appears on reg_map_data on the cycle after the DATA beat edge.
  - reg_wr_strobe and reg_wr_addr are registered and are high and valid that same cycle, for exactly one cycle.
- Response:
  - m_axis_tvalid rises the cycle after the tlast beat is accepted.
  - Each word holds stable until m_axis_tready is sampled high.
  - With m_axis_tready held high, words appear on 3 consecutive cycles.
  - s_axis_tready rises the cycle after word 2 is accepted.
- Minimum frame-to-frame gap at the input: 4 cycles with m_axis_tready held high.
- Consecutive DATA writes to the same register: the last write wins; no writes are merged.

## Test plan
- Write frame with REG_WIDTH=4, NUM_REG=6: 57575757, 00000005, 2, DEADBEEF (tlast) -> reg 2 = DEADBEEF; one strobe with addr 2; response 41434B21, 00000005, 00000001; cmd_id_out = 5.
- Three pairs with addresses 0, 9, 5 -> regs 0 and 5 written; status = 00010002.
- Odd payload: opcode, ID, addr 1 (tlast) -> no write; status = 40000000.
- Bad opcode 12345678 followed by 4 words, last one with tlast -> all words consumed, no writes; status = 80000000.
- Response back-pressure: m_axis_tready low for 10 cycles during RESP -> word 0 held stable; s_axis_tready stays 0; next frame accepted only after word 2.
- Reset asserted mid-DATA -> registers return to RESET_VAL and m_axis_tvalid = 0; a following clean frame decodes correctly.
